f1_delay: RTL and testbench

F1_DELAY -- requirements
Module: f1_delay

---
 rtl/f1_pkg.sv | 21 ++
 rtl/lfsr7.sv | 44 ++++
 rtl/f1_delay.sv | 119 +++++++++++
 tb/tb_f1_delay.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg -- shared definitions for the F1 random start-delay block.
//
// Contents:
//   LFSR_W_DEF : default width of the random generator / delay counter
//   SEED_DEF   : default (nonzero) LFSR reset value
//   state_t    : delay FSM state encoding (IDLE, COUNT, DONE, HOLD)
// ---------------------------------------------------------------------------
package f1_pkg;

    localparam int         LFSR_W_DEF = 7;
    localparam logic [6:0] SEED_DEF   = 7'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a trigger rising edge
        COUNT = 2'd1,   // counting ticks down from the latched K
        DONE  = 2'd2,   // one-cycle expiry, drives time_out
        HOLD  = 2'd3    // expired, waiting for trigger to drop
    } state_t;

endpackage

// File: rtl/lfsr7.sv
// ---------------------------------------------------------------------------
// lfsr7 -- free-running Fibonacci LFSR, x^7 + x^6 + 1 (period 127 for W=7).
// Advances on every rising clk edge; a nonzero seed keeps it out of the
// all-zero lock-up state, so the output is never zero.
//
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset, loads SEED
//   q   : current register contents (LFSR_W bits)
// ---------------------------------------------------------------------------
module lfsr7
    import f1_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_reg;
    logic [LFSR_W-1:0] q_next;

    // Shift left by one; feedback from the two top taps enters at bit 0.
    assign q_next[0] = q_reg[LFSR_W-1] ^ q_reg[LFSR_W-2];

    generate
        for (genvar gi = 1; gi < LFSR_W; gi++) begin : g_shift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/f1_delay.sv
// ---------------------------------------------------------------------------
// f1_delay -- random start delay for the F1 light sequence.
//
// A rising edge on trigger (in IDLE, with no abort) latches the current
// LFSR value K (1..127) and counts K ticks; the cycle after the K-th tick
// time_out pulses for one clk. A further delay needs trigger to fall and
// rise again. abort cancels any delay and wins over a simultaneous edge or
// expiry tick.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-low reset
//   tick      : one-clk timebase pulse; the delay counts these
//   trigger   : level command; only its rising edge starts a delay
//   abort     : synchronous cancel
//   time_out  : one-clk pulse when the delay expires (state decode)
//   busy      : high while counting or expiring
//   delay_val : K latched at the start of the current/last delay
// ---------------------------------------------------------------------------
module f1_delay
    import f1_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              trigger,
    input  logic              abort,
    output logic              time_out,
    output logic              busy,
    output logic [LFSR_W-1:0] delay_val
);

    logic [LFSR_W-1:0] lfsr_q;

    lfsr7 #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    state_t            state_reg;
    state_t            state_next;
    logic              trig_d_reg;
    logic              trig_edge;
    logic [LFSR_W-1:0] count_reg;
    logic [LFSR_W-1:0] count_next;
    logic [LFSR_W-1:0] delay_val_reg;
    logic [LFSR_W-1:0] delay_val_next;

    assign trig_edge = trigger & ~trig_d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            trig_d_reg    <= 1'b0;
            count_reg     <= '0;
            delay_val_reg <= '0;
        end else begin
            state_reg     <= state_next;
            trig_d_reg    <= trigger;
            count_reg     <= count_next;
            delay_val_reg <= delay_val_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        delay_val_next = delay_val_reg;

        if (abort) begin
            // Cancel wins over everything; count is deliberately left as is.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trig_edge) begin
                        // Pre-advance LFSR value; never zero, so K >= 1.
                        count_next     = lfsr_q;
                        delay_val_next = lfsr_q;
                        state_next     = COUNT;
                    end
                end
                COUNT: begin
                    if (tick) begin
                        if (count_reg == LFSR_W'(1)) begin
                            state_next = DONE;
                        end else begin
                            count_next = count_reg - LFSR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_next = trigger ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!trigger) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pure state decodes: no combinational path from any input.
    assign time_out  = (state_reg == DONE);
    assign busy      = (state_reg == COUNT) || (state_reg == DONE);
    assign delay_val = delay_val_reg;

endmodule

// File: tb/tb_f1_delay.sv
// ---------------------------------------------------------------------------
// tb_f1_delay -- self-checking bench for f1_delay.
// Table of {trigger clk, tick period, expected K} vectors plus hand-written
// sequences for abort, retrigger and reset corner cases. Expected delays are
// queued when a trigger is driven and retired when time_out is observed.
// ---------------------------------------------------------------------------
module tb_f1_delay;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tick    = 1'b0;
    logic       trigger = 1'b0;
    logic       abort   = 1'b0;
    logic       time_out;
    logic       busy;
    logic [6:0] delay_val;

    f1_delay #(
        .LFSR_W (7),
        .SEED   (7'h01)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .trigger   (trigger),
        .abort     (abort),
        .time_out  (time_out),
        .busy      (busy),
        .delay_val (delay_val)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int edge_cnt    = 0;
    int tick_period = 0;
    int tick_phase  = 0;
    bit tick_hist [0:131071];

    typedef struct {
        logic [6:0] k;
        int         latch;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         m;       // clk edge (after reset release) sampling the rise
        int         period;  // tick every 'period' clks
        logic [6:0] k;       // expected delay_val
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Retire a queued delay when time_out shows up; K ticks must have been
    // driven since the latching edge, the last of them on this very edge.
    task automatic monitor();
        exp_t e;
        int   n;
        if (rst && time_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_time_out", 1, 0);
            end else begin
                e = sb.pop_front();
                n = 0;
                for (int i = e.latch + 1; i <= edge_cnt; i++) n += int'(tick_hist[i]);
                chk("to_delay_val", int'(delay_val), int'(e.k));
                chk("to_tick_count", n, int'(e.k));
                chk("to_on_tick", int'(tick_hist[edge_cnt]), 1);
                chk("to_busy", int'(busy), 1);
                $display("txn: time_out k=%0d latched@%0d fired@%0d ticks=%0d",
                         e.k, e.latch, edge_cnt, n);
            end
        end
    endtask

    task automatic step();
        if (tick_period > 0) begin
            tick       = (tick_phase == 0);
            tick_phase = (tick_phase + 1) % tick_period;
        end else begin
            tick = 1'b0;
        end
        @(posedge clk);
        edge_cnt++;
        tick_hist[edge_cnt] = tick;
        #1;
        monitor();
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        trigger     = 1'b0;
        abort       = 1'b0;
        tick_period = 0;
        tick_phase  = 0;
        sb.delete();
        #1;
        chk("rst_time_out", int'(time_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_delay_val", int'(delay_val), 0);
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_sb(input int limit);
        for (int n = 0; n < limit && sb.size() != 0; n++) step();
        chk("time_out_seen", sb.size(), 0);
    endtask

    logic [6:0] model;
    int         latch;
    int         busy_cnt;
    int         to_cyc;

    initial begin
        vecs[0] = '{m: 3,  period: 1, k: 7'h04};
        vecs[1] = '{m: 1,  period: 4, k: 7'h01};
        vecs[2] = '{m: 7,  period: 1, k: 7'h41};
        vecs[3] = '{m: 8,  period: 2, k: 7'h03};
        vecs[4] = '{m: 13, period: 1, k: 7'h61};
        vecs[5] = '{m: 14, period: 1, k: 7'h42};
        vecs[6] = '{m: 15, period: 3, k: 7'h05};
        vecs[7] = '{m: 5,  period: 1, k: 7'h10};
        vecs[8] = '{m: 10, period: 2, k: 7'h0C};

        #2;

        // ---- LFSR free-run, observed through delay_val at each position ----
        model = 7'h01;
        for (int m = 1; m <= 128; m++) begin
            do_reset();
            for (int i = 1; i < m; i++) step();
            trigger = 1'b1;
            step();
            chk("lfsr_seq", int'(delay_val), int'(model));
            chk("lfsr_nonzero", int'(delay_val != 7'h00), 1);
            if (m == 128) chk("lfsr_wrap", int'(delay_val), 1);
            $display("lfsr clk %0d: delay_val=%02h", m, delay_val);
            model = {model[5:0], model[6] ^ model[5]};
        end

        // ---- Table-driven delays ----
        foreach (vecs[v]) begin
            do_reset();
            tick_period = vecs[v].period;
            tick_phase  = 0;
            for (int i = 1; i < vecs[v].m; i++) step();
            trigger = 1'b1;
            step();
            sb.push_back('{k: vecs[v].k, latch: edge_cnt});
            chk("latch_delay_val", int'(delay_val), int'(vecs[v].k));
            chk("latch_busy", int'(busy), 1);
            $display("vec %0d: rise at clk %0d period %0d delay_val=%0d",
                     v, vecs[v].m, vecs[v].period, delay_val);
            wait_sb(int'(vecs[v].k) * vecs[v].period + vecs[v].period + 4);
            step();
            chk("hold_busy", int'(busy), 0);
            chk("hold_time_out", int'(time_out), 0);
            trigger = 1'b0;
            step();
            chk("idle_busy", int'(busy), 0);
        end

        // ---- K=4, tick every clk: busy 5 clks, time_out in 5th cycle ----
        do_reset();
        tick_period = 1;
        step();
        step();
        trigger = 1'b1;
        step();
        latch = edge_cnt;
        sb.push_back('{k: 7'h04, latch: edge_cnt});
        busy_cnt = 0;
        to_cyc   = 0;
        for (int n = 0; n < 10; n++) begin
            if (busy) busy_cnt++;
            if (time_out) to_cyc = edge_cnt - latch + 1;
            step();
        end
        chk("k4_busy_clks", busy_cnt, 5);
        chk("k4_time_out_cycle", to_cyc, 5);
        chk("k4_retired", sb.size(), 0);
        $display("k4: busy %0d clks, time_out in cycle %0d", busy_cnt, to_cyc);
        trigger = 1'b0;
        step();

        // ---- abort at count 2 ----
        do_reset();
        tick_period = 1;
        step();
        step();
        trigger = 1'b1;
        step();                 // count 4
        step();                 // count 3
        step();                 // count 2
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_time_out", int'(time_out), 0);
        chk("abort_delay_val", int'(delay_val), 4);
        for (int n = 0; n < 6; n++) step();
        chk("abort_stays_idle", int'(busy), 0);
        $display("abort at count 2: busy=%0d", busy);

        // ---- abort coincident with the expiry tick, then abort + edge ----
        do_reset();
        tick_period = 1;
        step();
        step();
        trigger = 1'b1;
        step();                 // count 4
        step();                 // 3
        step();                 // 2
        step();                 // 1
        abort = 1'b1;
        step();                 // tick at count 1, abort wins
        abort = 1'b0;
        chk("abort_expiry_time_out", int'(time_out), 0);
        chk("abort_expiry_busy", int'(busy), 0);
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        abort   = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_edge_busy", int'(busy), 0);
        chk("abort_edge_delay_val", int'(delay_val), 4);
        step();
        chk("abort_edge_no_late_start", int'(busy), 0);
        for (int n = 0; n < 4; n++) step();
        $display("abort with expiry tick / with edge: busy=%0d delay_val=%0d", busy, delay_val);

        // ---- second trigger pulse during COUNT is ignored ----
        do_reset();
        tick_period = 2;
        step();
        step();
        trigger = 1'b1;
        step();
        sb.push_back('{k: 7'h04, latch: edge_cnt});
        step();
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        chk("retrig_delay_val", int'(delay_val), 4);
        chk("retrig_busy", int'(busy), 1);
        wait_sb(20);
        for (int n = 0; n < 10; n++) step();
        chk("retrig_hold_busy", int'(busy), 0);
        $display("retrigger in COUNT: delay_val=%0d", delay_val);
        trigger = 1'b0;
        step();

        // ---- reset mid-COUNT, trigger high across reset release ----
        do_reset();
        tick_period = 1;
        for (int n = 0; n < 6; n++) step();
        trigger = 1'b1;
        step();                 // K = 0x41
        for (int n = 0; n < 5; n++) step();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("midrst_time_out", int'(time_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_delay_val", int'(delay_val), 0);
        step();
        step();
        rst = 1'b1;
        step();                 // trigger already high: edge on first clk
        sb.push_back('{k: 7'h01, latch: edge_cnt});
        chk("rel_delay_val", int'(delay_val), 1);
        chk("rel_busy", int'(busy), 1);
        wait_sb(5);
        $display("reset mid-COUNT: relaunch delay_val=%0d", delay_val);
        trigger = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
